// File: rtl/mul_iter_unit_if.sv
// Operand/result bundle between the issue stage, the iterative multiplier and writeback.
// Latency: none (wires only).
// Backpressure: in_ready/in_valid on the issue side; out_valid/out_ready on the writeback side.
//
// Ports (signals):
//   flush, in_valid, ismultiply, srca, srcb, dest, out_ready   : issue/writeback -> unit
//   in_ready, out_valid, result, out_dest, stall               : unit -> issue/writeback
interface mul_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             ismultiply;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [4:0]       dest;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       out_dest;
  logic             stall;

  // Pipeline side: issues operands and accepts results.
  modport master (
    output flush, in_valid, ismultiply, srca, srcb, dest, out_ready,
    input  in_ready, out_valid, result, out_dest, stall
  );

  // Multiplier side.
  modport slave (
    input  flush, in_valid, ismultiply, srca, srcb, dest, out_ready,
    output in_ready, out_valid, result, out_dest, stall
  );
endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier returning the low WIDTH bits of srca*srcb, STEP multiplier bits per cycle.
// Latency: ceil((msb(srcb)+1)/STEP)+1 BUSY cycles after accept (1 when srcb==0), then result held in DONE.
// Backpressure: result held until out_ready; in_ready low and stall high while an op is in flight.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mul_iter_unit_if.slave: flush, operand bundle (in_valid/in_ready), result bundle
//            (out_valid/out_ready), stall to the issue stage
module mul_iter_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  mul_iter_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [4:0]       out_dest_q,  out_dest_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] partial;
  logic             in_ready_c;
  logic             accept;
  logic             stall_c;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_dest_d  = out_dest_q;
    out_valid_d = out_valid_q;

    // mcand * mplier[STEP-1:0] as a small shift-add; wraps mod 2^WIDTH.
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end

    in_ready_c = (state_q == IDLE) & ~bus.flush;
    accept     = bus.in_valid & bus.ismultiply & in_ready_c;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d    = bus.srca;
          mplier_d   = bus.srcb;
          acc_d      = '0;
          out_dest_d = bus.dest;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Terminate as soon as no multiplier bits remain, so short operands finish early.
        if (mplier_q == '0) begin
          result_d    = acc_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << STEP;
          mplier_d = mplier_q >> STEP;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Flush wins over everything; a flushed op must not overwrite the visible result.
    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end

    stall_c = (state_q == BUSY)
            | ((state_q == DONE) & ~bus.out_ready)
            | (bus.in_valid & bus.ismultiply & ~in_ready_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_dest_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_dest_q  <= out_dest_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_dest  = out_dest_q;
  assign bus.stall     = stall_c;

endmodule
